// File: rtl/stack_pkg.sv
// Shared definitions for the data-memory stack: request op encodings, the
// engine state enum and the default stack geometry.
package stack_pkg;

    localparam logic [1:0] OP_PUSH  = 2'd0;
    localparam logic [1:0] OP_POP   = 2'd1;
    localparam logic [1:0] OP_PEEK  = 2'd2;
    localparam logic [1:0] OP_FLUSH = 2'd3;

    localparam int         DEF_DATA_W      = 16;
    localparam int         DEF_ADDR_W      = 8;
    localparam logic [7:0] DEF_STACK_BASE  = 8'h10;
    localparam logic [7:0] DEF_STACK_LIMIT = 8'h00;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PUSH  = 3'd1,
        READ  = 3'd2,
        WAIT  = 3'd3,
        FLUSH = 3'd4,
        RESP  = 3'd5
    } state_e;

endpackage

// File: rtl/stack_pointer.sv
// Stack pointer register steered by the engine's one-cycle strobes.
// Resets to STACK_BASE (empty full-descending stack).
module stack_pointer
    import stack_pkg::*;
#(
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] STACK_BASE = ADDR_W'(DEF_STACK_BASE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inr_SP,
    input  logic              dcr_SP,
    input  logic              SP_load_en,
    input  logic [ADDR_W-1:0] SP_load,
    output logic [ADDR_W-1:0] SP
);

    logic [ADDR_W-1:0] sp_q, sp_d;

    always_comb begin
        sp_d = sp_q;
        if (SP_load_en) begin
            sp_d = SP_load;
        end else if (inr_SP) begin
            sp_d = sp_q + ADDR_W'(1);
        end else if (dcr_SP) begin
            sp_d = sp_q - ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q <= STACK_BASE;
        end else begin
            sp_q <= sp_d;
        end
    end

    assign SP = sp_q;

endmodule

// File: rtl/stack_engine.sv
// Sequencing controller for the data-memory stack: accepts PUSH/POP/PEEK/FLUSH
// requests, drives the memory port and the stack_pointer strobes, returns a response.
module stack_engine
    import stack_pkg::*;
#(
    parameter int                DATA_W      = DEF_DATA_W,
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] STACK_BASE  = ADDR_W'(DEF_STACK_BASE),
    parameter logic [ADDR_W-1:0] STACK_LIMIT = ADDR_W'(DEF_STACK_LIMIT)
) (
    input  logic              clk,
    input  logic              reset,
    // Both channels: a transfer happens on the rising edge where valid and
    // ready are both high; valid never depends on ready, and response
    // payload stays stable while rsp_valid is high and rsp_ready is low.
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    input  logic [ADDR_W-1:0] SP,
    output logic              inr_SP,
    output logic              dcr_SP,
    output logic              SP_load_en,
    output logic [ADDR_W-1:0] SP_load,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              full,
    output logic              empty,
    output logic [2:0]        dbg_state
);

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;
    logic              req_is_read;
    logic              req_err;

    assign full  = (SP == STACK_LIMIT);
    assign empty = (SP == STACK_BASE);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        req_is_read = (req_op == OP_POP) || (req_op == OP_PEEK);
        req_err     = ((req_op == OP_PUSH) && full) || (req_is_read && empty);

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d       = req_op;
                    data_d     = req_data;
                    rsp_data_d = '0;
                    rsp_err_d  = req_err;
                    if (req_err) begin
                        state_d = RESP;
                    end else begin
                        case (req_op)
                            OP_PUSH:  state_d = PUSH;
                            OP_FLUSH: state_d = FLUSH;
                            default:  state_d = READ;
                        endcase
                    end
                end
            end
            PUSH:  state_d = RESP;
            READ:  state_d = WAIT;
            WAIT: begin
                // Synchronous RAM: data from the READ-cycle access lands here.
                rsp_data_d = mem_rdata;
                state_d    = RESP;
            end
            FLUSH: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes come only from registered state and captured op, and are
    // suppressed while reset is high so an abandoned op leaves no trace.
    always_comb begin
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        inr_SP     = 1'b0;
        dcr_SP     = 1'b0;
        SP_load_en = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = SP;
        if (!reset) begin
            case (state_q)
                IDLE: req_ready = 1'b1;
                PUSH: begin
                    mem_we   = 1'b1;
                    mem_addr = SP - ADDR_W'(1);
                    dcr_SP   = 1'b1;
                end
                READ: begin
                    mem_re = 1'b1;
                    inr_SP = (op_q == OP_POP);
                end
                FLUSH: SP_load_en = 1'b1;
                RESP:  rsp_valid  = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= OP_PUSH;
            data_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            data_q     <= data_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign mem_wdata = data_q;
    assign SP_load   = STACK_BASE;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_stack_engine.sv
// Bench for stack_engine + stack_pointer + behavioural RAM, checked against a
// queue-based stack model with directed and randomized operations.
module tb_stack_engine;
    import stack_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic [7:0]  sp;
    logic        inr_sp, dcr_sp, sp_load_en;
    logic [7:0]  sp_load;
    logic [7:0]  mem_addr;
    logic        mem_we, mem_re;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        full, empty;
    logic [2:0]  dbg_state;

    logic [15:0] ram [256];
    logic [15:0] model_stk[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stack_engine dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .SP(sp), .inr_SP(inr_sp), .dcr_SP(dcr_sp), .SP_load_en(sp_load_en), .SP_load(sp_load),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .full(full), .empty(empty), .dbg_state(dbg_state)
    );

    stack_pointer u_sp (
        .clk(clk), .reset(reset),
        .inr_SP(inr_sp), .dcr_SP(dcr_sp), .SP_load_en(sp_load_en), .SP_load(sp_load),
        .SP(sp)
    );

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_sp_view();
        int depth;
        depth = model_stk.size();
        check_eq("sp", sp, 32'(8'h10 - depth));
        check_eq("empty", empty, (depth == 0));
        check_eq("full", full, (depth == 16));
    endtask

    // Issue one request, observe every cycle until the response handshake,
    // then compare against what the stack model says should have happened.
    task automatic run_op(input logic [1:0] op, input logic [15:0] data, input int hold);
        int          depth, lat, exp_lat;
        int          n_we, n_re, n_inr, n_dcr, n_ld, n_multi;
        logic [7:0]  we_addr, re_addr;
        logic [15:0] we_data, d, exp_data;
        logic        e, exp_err, is_rd;
        depth   = model_stk.size();
        is_rd   = (op == OP_POP) || (op == OP_PEEK);
        exp_err = ((op == OP_PUSH) && depth == 16) || (is_rd && depth == 0);
        exp_lat = exp_err ? 1 : (is_rd ? 3 : 2);
        exp_data = 16'h0;
        if (is_rd && !exp_err) exp_data = model_stk[depth-1];
        n_we = 0; n_re = 0; n_inr = 0; n_dcr = 0; n_ld = 0; n_multi = 0;
        we_addr = 8'h0; re_addr = 8'h0; we_data = 16'h0; d = 16'h0; e = 1'b0;

        @(negedge clk);
        check_eq("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = data;
        rsp_ready = (hold == 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_data  = 16'($urandom);

        lat = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (mem_we) begin n_we++; we_addr = mem_addr; we_data = mem_wdata; end
            if (mem_re) begin n_re++; re_addr = mem_addr; end
            n_inr += int'(inr_sp);
            n_dcr += int'(dcr_sp);
            n_ld  += int'(sp_load_en);
            if (int'(inr_sp) + int'(dcr_sp) + int'(sp_load_en) > 1) n_multi++;
            if (lat < 0 && rsp_valid) begin
                lat = cyc;
                d   = rsp_data;
                e   = rsp_err;
            end
            if (lat >= 0) begin
                if (cyc > lat) begin
                    check_eq("rsp_valid_held", rsp_valid, 1);
                    check_eq("rsp_data_stable", rsp_data, d);
                    check_eq("rsp_err_stable", rsp_err, e);
                end
                if (cyc - lat < hold) begin
                    check_eq("req_ready_busy", req_ready, 0);
                end else begin
                    rsp_ready = 1'b1;
                    @(posedge clk);
                    #1;
                    break;
                end
            end
        end
        rsp_ready = 1'b1;

        check_eq("rsp_latency", lat, exp_lat);
        check_eq("rsp_err", e, exp_err);
        check_eq("rsp_data", d, exp_data);
        check_eq("n_mem_we", n_we, (op == OP_PUSH && !exp_err) ? 1 : 0);
        check_eq("n_mem_re", n_re, (is_rd && !exp_err) ? 1 : 0);
        check_eq("n_inr_sp", n_inr, (op == OP_POP && !exp_err) ? 1 : 0);
        check_eq("n_dcr_sp", n_dcr, (op == OP_PUSH && !exp_err) ? 1 : 0);
        check_eq("n_sp_load", n_ld, (op == OP_FLUSH) ? 1 : 0);
        check_eq("multi_strobe", n_multi, 0);
        if (op == OP_PUSH && !exp_err) begin
            check_eq("we_addr", we_addr, 32'(8'h10 - depth - 1));
            check_eq("we_data", we_data, data);
        end
        if (is_rd && !exp_err) check_eq("re_addr", re_addr, 32'(8'h10 - depth));

        if (!exp_err) begin
            case (op)
                OP_PUSH:  model_stk.push_back(data);
                OP_POP:   void'(model_stk.pop_back());
                OP_FLUSH: model_stk.delete();
                default:  ;
            endcase
        end
        check_sp_view();
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = OP_PUSH;
        req_data  = 16'h0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("reset_req_ready", req_ready, 1);
        check_eq("reset_rsp_valid", rsp_valid, 0);
        check_eq("reset_rsp_data", rsp_data, 0);
        check_eq("reset_rsp_err", rsp_err, 0);
        check_eq("reset_strobes", {mem_we, mem_re, inr_sp, dcr_sp, sp_load_en}, 0);
        check_eq("reset_sp_load", sp_load, 8'h10);
        check_sp_view();

        run_op(OP_PUSH, 16'hABCD, 0);
        run_op(OP_FLUSH, 16'h0, 0);
        run_op(OP_PUSH, 16'h1111, 0);
        run_op(OP_PUSH, 16'h2222, 0);
        run_op(OP_POP, 16'h0, 0);
        run_op(OP_POP, 16'h0, 0);
        run_op(OP_PUSH, 16'h5A5A, 0);
        run_op(OP_PEEK, 16'h0, 0);
        run_op(OP_POP, 16'h0, 0);
        run_op(OP_POP, 16'h0, 0);
        run_op(OP_PEEK, 16'h0, 1);
        for (int i = 0; i < 16; i++) run_op(OP_PUSH, 16'($urandom), 0);
        run_op(OP_PUSH, 16'hDEAD, 0);
        run_op(OP_POP, 16'h0, 5);
        run_op(OP_FLUSH, 16'h0, 0);
        for (int i = 0; i < 4; i++) run_op(OP_PUSH, 16'($urandom), 0);
        run_op(OP_FLUSH, 16'h0, 0);

        for (int i = 0; i < 300; i++) begin
            int sel;
            logic [1:0] op;
            sel = $urandom_range(0, 19);
            if (sel < 9)       op = OP_PUSH;
            else if (sel < 15) op = OP_POP;
            else if (sel < 19) op = OP_PEEK;
            else               op = OP_FLUSH;
            run_op(op, 16'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
        end

        // Reset during the READ cycle of a POP.
        run_op(OP_PUSH, 16'h1234, 0);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_POP;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        check_eq("rstmid_strobes", {mem_we, mem_re, inr_sp, dcr_sp, sp_load_en}, 0);
        check_eq("rstmid_rsp_valid", rsp_valid, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_stk.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("post_rst_req_ready", req_ready, 1);
            check_eq("post_rst_rsp_valid", rsp_valid, 0);
            check_eq("post_rst_strobes", {mem_we, mem_re, inr_sp, dcr_sp, sp_load_en}, 0);
        end
        check_sp_view();
        run_op(OP_FLUSH, 16'h0, 0);
        run_op(OP_PUSH, 16'h7777, 0);
        run_op(OP_POP, 16'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
